// File: rtl/vc_input_buffer.sv
// vc_input_buffer
// ---------------------------------------------------------------------------
// Two-virtual-channel flit buffer placed in front of one router input port.
// Upstream flits are stored in one FIFO per VC. A VC is then chosen by
// round-robin, subject to the router's per-VC packet lock. The chosen flit is
// presented through a single registered holding stage.
//
// Handshake semantics (both sides):
//   Upstream:   a flit is accepted when S_VALID && S_RDY[S_VCH]. S_RDY depends
//               only on registered occupancy. A valid flit on a VC whose S_RDY
//               is low is dropped and latches S_OVF.
//   Downstream: a transfer happens when OVALID && D_RDY[OVCH]. Once OVALID is
//               high, ODATA/OVCH stay frozen and OVALID stays high until that
//               transfer.
//
// Ports:
//   clk, RST_          clock (rising edge); asynchronous active-low reset
//   S_DATA/S_VALID/S_VCH  upstream flit, valid and VC select
//   S_RDY[1:0]         per-VC "FIFO not full"
//   S_OVF              sticky overflow (flit dropped), cleared only by reset
//   ODATA/OVALID/OVCH  registered flit to router IDATA/IVALID/IVCH
//   D_RDY[1:0]         router per-VC ready
//   D_LCK[1:0]         router per-VC packet-in-progress lock
//   FLIT_CNT_0/1       per-VC forwarded-flit counters
//
// Configuration macro: VCBUF_CNT_EN
//   When defined, the 16-bit wrapping flit counters are built.
//   When undefined, FLIT_CNT_0/FLIT_CNT_1 are tied to zero.
// ---------------------------------------------------------------------------
module vc_input_buffer #(
    parameter int DW    = 35,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          RST_,
    input  logic [DW-1:0] S_DATA,
    input  logic          S_VALID,
    input  logic          S_VCH,
    output logic [1:0]    S_RDY,
    output logic          S_OVF,
    output logic [DW-1:0] ODATA,
    output logic          OVALID,
    output logic          OVCH,
    input  logic [1:0]    D_RDY,
    input  logic [1:0]    D_LCK,
    output logic [15:0]   FLIT_CNT_0,
    output logic [15:0]   FLIT_CNT_1
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DW-1:0] r_mem [2][DEPTH];
    logic [PW-1:0] r_wptr [2];
    logic [PW-1:0] r_rptr [2];
    logic          r_prio;
    logic          r_lastvc;

    logic [1:0]    w_full;
    logic [1:0]    w_empty;
    logic [1:0]    w_push;
    logic [1:0]    w_pop;
    logic [1:0]    w_elig;
    logic          w_xfer;
    logic          w_can_load;
    logic          w_cur_vc;
    logic          w_lock;
    logic          w_sel;
    logic          w_load;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;

    always_comb begin
        for (int v = 0; v < 2; v++) begin
            w_empty[v] = (r_wptr[v] == r_rptr[v]);
            w_full[v]  = (r_wptr[v][AW] != r_rptr[v][AW]) &&
                         (r_wptr[v][AW-1:0] == r_rptr[v][AW-1:0]);
        end
    end

    assign S_RDY = ~w_full;

    assign w_push[0] = S_VALID && !S_VCH && S_RDY[0];
    assign w_push[1] = S_VALID &&  S_VCH && S_RDY[1];

    assign w_xfer     = OVALID && D_RDY[OVCH];
    assign w_can_load = !OVALID || w_xfer;

    // The lock refers to the VC of the most recent transfer. When a transfer
    // happens this cycle, that VC is OVCH, not the registered r_lastvc.
    assign w_cur_vc = w_xfer ? OVCH : r_lastvc;
    assign w_lock   = D_LCK[w_cur_vc];

    assign w_elig[0] = !w_empty[0] && (!w_lock || !w_cur_vc);
    assign w_elig[1] = !w_empty[1] && (!w_lock ||  w_cur_vc);

    // The pointer only matters when both VCs compete. Otherwise the single
    // eligible VC is taken.
    assign w_sel  = (w_elig == 2'b11) ? r_prio : w_elig[1];
    assign w_load = w_can_load && (|w_elig);

    assign w_pop[0] = w_load && !w_sel;
    assign w_pop[1] = w_load &&  w_sel;

    assign w_wr_idx = S_VCH ? r_wptr[1][AW-1:0] : r_wptr[0][AW-1:0];
    assign w_rd_idx = w_sel ? r_rptr[1][AW-1:0] : r_rptr[0][AW-1:0];

    // Storage is not reset; validity is carried entirely by the pointers.
    always_ff @(posedge clk) begin
        if (|w_push) begin
            r_mem[S_VCH][w_wr_idx] <= S_DATA;
        end
    end

    always_ff @(posedge clk or negedge RST_) begin
        if (!RST_) begin
            r_wptr[0] <= '0;
            r_wptr[1] <= '0;
            r_rptr[0] <= '0;
            r_rptr[1] <= '0;
            S_OVF     <= 1'b0;
        end else begin
            for (int v = 0; v < 2; v++) begin
                if (w_push[v]) r_wptr[v] <= r_wptr[v] + 1'b1;
                if (w_pop[v])  r_rptr[v] <= r_rptr[v] + 1'b1;
            end
            if (S_VALID && !S_RDY[S_VCH]) begin
                S_OVF <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge RST_) begin
        if (!RST_) begin
            OVALID   <= 1'b0;
            OVCH     <= 1'b0;
            ODATA    <= '0;
            r_prio   <= 1'b0;
            r_lastvc <= 1'b0;
        end else begin
            if (w_load) begin
                ODATA  <= r_mem[w_sel][w_rd_idx];
                OVCH   <= w_sel;
                OVALID <= 1'b1;
                r_prio <= ~w_sel;
            end else if (w_xfer) begin
                OVALID <= 1'b0;
            end
            if (w_xfer) begin
                r_lastvc <= OVCH;
            end
        end
    end

`ifdef VCBUF_CNT_EN
    logic [15:0] r_cnt0;
    logic [15:0] r_cnt1;

    always_ff @(posedge clk or negedge RST_) begin
        if (!RST_) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_xfer) begin
            if (OVCH) r_cnt1 <= r_cnt1 + 16'd1;
            else      r_cnt0 <= r_cnt0 + 16'd1;
        end
    end

    assign FLIT_CNT_0 = r_cnt0;
    assign FLIT_CNT_1 = r_cnt1;
`else
    assign FLIT_CNT_0 = 16'd0;
    assign FLIT_CNT_1 = 16'd0;
`endif

endmodule

// File: tb/tb_vc_input_buffer.sv
// tb_vc_input_buffer
// Self-checking bench for vc_input_buffer. A negedge monitor pops the expected
// {vc, data} queue on every transfer. Scenario tasks add inline cycle checks.
module tb_vc_input_buffer;

    localparam int DW    = 35;
    localparam int DEPTH = 4;
    localparam int EW    = DW + 1;
`ifdef VCBUF_CNT_EN
    localparam logic [15:0] CNT_AFTER_3 = 16'd3;
`else
    localparam logic [15:0] CNT_AFTER_3 = 16'd0;
`endif

    logic          clk = 1'b0;
    logic          RST_;
    logic [DW-1:0] S_DATA;
    logic          S_VALID;
    logic          S_VCH;
    logic [1:0]    S_RDY;
    logic          S_OVF;
    logic [DW-1:0] ODATA;
    logic          OVALID;
    logic          OVCH;
    logic [1:0]    D_RDY;
    logic [1:0]    D_LCK;
    logic [15:0]   FLIT_CNT_0;
    logic [15:0]   FLIT_CNT_1;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] sb_exp;
    int            checks = 0;
    int            passes = 0;

    vc_input_buffer #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .RST_       (RST_),
        .S_DATA     (S_DATA),
        .S_VALID    (S_VALID),
        .S_VCH      (S_VCH),
        .S_RDY      (S_RDY),
        .S_OVF      (S_OVF),
        .ODATA      (ODATA),
        .OVALID     (OVALID),
        .OVCH       (OVCH),
        .D_RDY      (D_RDY),
        .D_LCK      (D_LCK),
        .FLIT_CNT_0 (FLIT_CNT_0),
        .FLIT_CNT_1 (FLIT_CNT_1)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (RST_ === 1'b1 && OVALID === 1'b1 && D_RDY[OVCH] === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_extra: got vc=%0d data=%h, required no transfer", OVCH, ODATA);
            end else begin
                sb_exp = exp_q.pop_front();
                if ({OVCH, ODATA} !== sb_exp)
                    $display("FAIL sb_flit: got vc=%0d data=%h, required vc=%0d data=%h",
                             OVCH, ODATA, sb_exp[EW-1], sb_exp[DW-1:0]);
                else
                    passes++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [DW-1:0] rand_flit();
        logic [2:0]  hi;
        logic [31:0] lo;
        hi = 3'($urandom_range(7));
        lo = $urandom;
        return {hi, lo};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one write for one cycle. 'accept' is the bench's prediction.
    task automatic drive_write(input logic vc, input logic [DW-1:0] d, input bit accept);
        S_VALID = 1'b1;
        S_VCH   = vc;
        S_DATA  = d;
        if (accept) exp_q.push_back({vc, d});
        @(posedge clk);
        #1;
        S_VALID = 1'b0;
    endtask

    task automatic do_reset();
        RST_    = 1'b0;
        S_VALID = 1'b0;
        S_VCH   = 1'b0;
        S_DATA  = '0;
        D_RDY   = 2'b00;
        D_LCK   = 2'b00;
        exp_q.delete();
        idle(2);
        RST_ = 1'b1;
        idle(1);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL drain_timeout: got %0d flits pending, required 0", exp_q.size());
        else
            passes++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (OVALID !== 1'b0) $display("FAIL rst_ovalid: got %b, required 0", OVALID); else passes++;
        checks++; if (OVCH !== 1'b0) $display("FAIL rst_ovch: got %b, required 0", OVCH); else passes++;
        checks++; if (ODATA !== '0) $display("FAIL rst_odata: got %h, required 0", ODATA); else passes++;
        checks++; if (S_OVF !== 1'b0) $display("FAIL rst_ovf: got %b, required 0", S_OVF); else passes++;
        checks++; if (S_RDY !== 2'b11) $display("FAIL rst_srdy: got %b, required 11", S_RDY); else passes++;
        checks++; if (FLIT_CNT_0 !== 16'd0 || FLIT_CNT_1 !== 16'd0)
            $display("FAIL rst_cnt: got %0d/%0d, required 0/0", FLIT_CNT_0, FLIT_CNT_1); else passes++;
    endtask

    task automatic test_single_flit();
        logic [DW-1:0] d;
        do_reset();
        d     = 35'h1_2345_6789;
        D_RDY = 2'b11;
        drive_write(1'b1, d, 1'b1);   // cycle 0
        checks++; if (OVALID !== 1'b0) $display("FAIL single_c1_ovalid: got %b, required 0", OVALID); else passes++;
        idle(1);                      // cycle 2
        checks++; if (OVALID !== 1'b1 || OVCH !== 1'b1 || ODATA !== d)
            $display("FAIL single_c2: got v=%b vc=%b d=%h, required v=1 vc=1 d=%h", OVALID, OVCH, ODATA, d);
        else passes++;
        idle(1);                      // cycle 3
        checks++; if (OVALID !== 1'b0) $display("FAIL single_c3_ovalid: got %b, required 0", OVALID); else passes++;
        wait_drain(5);
    endtask

    task automatic test_overflow();
        do_reset();
        D_RDY = 2'b00;
        // One flit moves into the holding stage, so DEPTH+1 writes fit.
        for (int k = 1; k <= DEPTH + 1; k++) begin
            drive_write(1'b0, rand_flit(), 1'b1);
            checks++;
            if (S_RDY !== {1'b1, (k <= DEPTH)} || S_OVF !== 1'b0)
                $display("FAIL fill_w%0d: got rdy=%b ovf=%b, required rdy=%b ovf=0",
                         k, S_RDY, S_OVF, {1'b1, (k <= DEPTH)});
            else passes++;
        end
        drive_write(1'b0, rand_flit(), 1'b0);
        checks++; if (S_OVF !== 1'b1 || S_RDY !== 2'b10)
            $display("FAIL ovf_drop: got ovf=%b rdy=%b, required ovf=1 rdy=10", S_OVF, S_RDY);
        else passes++;
        D_RDY = 2'b11;
        wait_drain(30);
        idle(2);
        checks++; if (S_OVF !== 1'b1 || OVALID !== 1'b0 || S_RDY !== 2'b11)
            $display("FAIL ovf_sticky: got ovf=%b v=%b rdy=%b, required ovf=1 v=0 rdy=11", S_OVF, OVALID, S_RDY);
        else passes++;
    endtask

    task automatic test_round_robin();
        logic [5:0] seq;
        do_reset();
        seq = 6'b101010;   // bit i = expected OVCH of i-th consecutive cycle
        for (int i = 0; i < 3; i++) begin
            drive_write(1'b0, rand_flit(), 1'b1);
            drive_write(1'b1, rand_flit(), 1'b1);
        end
        D_RDY = 2'b11;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (OVALID !== 1'b1 || OVCH !== seq[i])
                $display("FAIL rr_seq%0d: got v=%b vc=%b, required v=1 vc=%b", i, OVALID, OVCH, seq[i]);
            else passes++;
        end
        wait_drain(5);
        checks++; if (OVALID !== 1'b0) $display("FAIL rr_end: got %b, required 0", OVALID); else passes++;
    endtask

    task automatic test_lock();
        do_reset();
        for (int i = 0; i < 3; i++) drive_write(1'b0, rand_flit(), 1'b1);
        for (int i = 0; i < 3; i++) drive_write(1'b1, rand_flit(), 1'b1);
        // Router locks VC0 while accepting its head flit.
        D_LCK = 2'b01;
        D_RDY = 2'b11;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (i < 3 ? (OVALID !== 1'b1 || OVCH !== 1'b0) : (OVALID !== 1'b0))
                $display("FAIL lock_c%0d: got v=%b vc=%b, required v=%b vc=0", i, OVALID, OVCH, (i < 3));
            else passes++;
        end
        @(posedge clk); #1;
        D_LCK = 2'b00;
        @(negedge clk);
        checks++; if (OVALID !== 1'b0) $display("FAIL unlock_c0: got %b, required 0", OVALID); else passes++;
        @(negedge clk);
        checks++; if (OVALID !== 1'b1 || OVCH !== 1'b1)
            $display("FAIL unlock_c1: got v=%b vc=%b, required v=1 vc=1", OVALID, OVCH);
        else passes++;
        wait_drain(10);
    endtask

    task automatic test_back_to_back_stall();
        logic [DW-1:0] f0;
        logic [DW-1:0] f1;
        do_reset();
        f0 = rand_flit();
        f1 = rand_flit();
        drive_write(1'b1, f0, 1'b1);
        drive_write(1'b1, f1, 1'b1);
        D_RDY = 2'b01;   // only the other VC is ready
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (OVALID !== 1'b1 || OVCH !== 1'b1 || ODATA !== f0)
                $display("FAIL stall_c%0d: got v=%b vc=%b d=%h, required v=1 vc=1 d=%h", i, OVALID, OVCH, ODATA, f0);
            else passes++;
        end
        @(posedge clk); #1;
        D_RDY = 2'b11;
        @(negedge clk);
        @(negedge clk);
        checks++; if (OVALID !== 1'b1 || ODATA !== f1)
            $display("FAIL stall_next: got v=%b d=%h, required v=1 d=%h", OVALID, ODATA, f1);
        else passes++;
        wait_drain(5);
    endtask

    task automatic test_reset_counter();
        do_reset();
        D_RDY = 2'b11;
        for (int i = 0; i < 3; i++) drive_write(1'b0, rand_flit(), 1'b1);
        wait_drain(10);
        checks++; if (FLIT_CNT_0 !== CNT_AFTER_3 || FLIT_CNT_1 !== 16'd0)
            $display("FAIL cnt3: got %0d/%0d, required %0d/0", FLIT_CNT_0, FLIT_CNT_1, CNT_AFTER_3);
        else passes++;
        D_RDY = 2'b00;
        for (int i = 0; i < 3; i++) drive_write(1'b0, rand_flit(), 1'b0);
        checks++; if (OVALID !== 1'b1) $display("FAIL pre_rst_held: got %b, required 1", OVALID); else passes++;
        #2;
        RST_ = 1'b0;
        exp_q.delete();
        #1;
        checks++; if (OVALID !== 1'b0 || FLIT_CNT_0 !== 16'd0 || S_RDY !== 2'b11)
            $display("FAIL async_rst: got v=%b cnt=%0d rdy=%b, required v=0 cnt=0 rdy=11", OVALID, FLIT_CNT_0, S_RDY);
        else passes++;
        idle(2);
        RST_  = 1'b1;
        D_RDY = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (OVALID !== 1'b0 || S_RDY !== 2'b11)
                $display("FAIL post_rst_c%0d: got v=%b rdy=%b, required v=0 rdy=11", i, OVALID, S_RDY);
            else passes++;
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_single_flit();
        test_overflow();
        test_round_robin();
        test_lock();
        test_back_to_back_stall();
        test_reset_counter();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
